// File: rtl/digit_scan_mux.sv
// Multiplexed 4-digit display scanner with frame-coherent updates.
// Define DIGIT_BLANK_EN to enable leading-zero blanking on DS2/DS3.
module digit_scan_mux #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eoc,
    input  logic       du,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hund,
    input  logic       thou,
    input  logic       pol,
    input  logic       ovr,
    input  logic       udr,
    output logic [3:0] ds,
    output logic [3:0] q,
    output logic       upd
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);

    typedef enum logic [3:0] {
        DS1 = 4'b1000,
        DS2 = 4'b0100,
        DS3 = 4'b0010,
        DS4 = 4'b0001
    } scan_t;

    scan_t         r_state;
    scan_t         w_state_nxt;
    logic [DW-1:0] r_div;
    logic [15:0]   r_sh;
    logic [15:0]   r_disp;
    logic          r_pend;
    logic [3:0]    r_q;
    logic          r_upd;

    logic          w_wrap;
    logic          w_cap;
    logic          w_xfer;
    logic [15:0]   w_disp_nxt;
    logic [3:0]    w_q_nxt;

    assign w_wrap     = (r_div == DMAX);
    assign w_cap      = eoc & du;
    assign w_xfer     = w_wrap & (r_state == DS4) & r_pend;
    assign w_disp_nxt = w_xfer ? r_sh : r_disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_wrap) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DS1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_wrap) begin
            unique case (r_state)
                DS1:     w_state_nxt = DS2;
                DS2:     w_state_nxt = DS3;
                DS3:     w_state_nxt = DS4;
                DS4:     w_state_nxt = DS1;
                default: w_state_nxt = DS1;
            endcase
        end
    end

    // Transfer reads the old shadow before a same-edge capture overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_pend <= 1'b0;
            r_disp <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= w_xfer;
            if (w_xfer) begin
                r_disp <= r_sh;
            end
            if (w_cap) begin
                r_sh   <= {thou, pol, ovr, udr, hund, tens, units};
                r_pend <= 1'b1;
            end else if (w_xfer) begin
                r_pend <= 1'b0;
            end
        end
    end

`ifdef DIGIT_BLANK_EN
    logic w_blank2;
    logic w_blank3;

    assign w_blank2 = ~w_disp_nxt[15] & (w_disp_nxt[11:8] == 4'd0);
    assign w_blank3 = w_blank2 & (w_disp_nxt[7:4] == 4'd0);

    always_comb begin
        w_q_nxt = w_disp_nxt[15:12];
        unique case (w_state_nxt)
            DS1:     w_q_nxt = w_disp_nxt[15:12];
            DS2:     w_q_nxt = w_blank2 ? 4'hF : w_disp_nxt[11:8];
            DS3:     w_q_nxt = w_blank3 ? 4'hF : w_disp_nxt[7:4];
            DS4:     w_q_nxt = w_disp_nxt[3:0];
            default: w_q_nxt = w_disp_nxt[15:12];
        endcase
    end
`else
    always_comb begin
        w_q_nxt = w_disp_nxt[15:12];
        unique case (w_state_nxt)
            DS1:     w_q_nxt = w_disp_nxt[15:12];
            DS2:     w_q_nxt = w_disp_nxt[11:8];
            DS3:     w_q_nxt = w_disp_nxt[7:4];
            DS4:     w_q_nxt = w_disp_nxt[3:0];
            default: w_q_nxt = w_disp_nxt[15:12];
        endcase
    end
`endif

    // q follows the strobe it will be shown with, so it loads with ds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'b0000;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign ds  = r_state;
    assign q   = r_q;
    assign upd = r_upd;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux: cycle model vs DUT each cycle.
// Model derives strobe position arithmetically from cycles since reset.
module tb_digit_scan_mux;

    localparam int SD = 16;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eoc = 1'b0;
    logic       du = 1'b0;
    logic [3:0] units = '0;
    logic [3:0] tens = '0;
    logic [3:0] hund = '0;
    logic       thou = 1'b0;
    logic       pol = 1'b0;
    logic       ovr = 1'b0;
    logic       udr = 1'b0;
    logic [3:0] ds;
    logic [3:0] q;
    logic       upd;

    int n_tests = 0;
    int n_fail = 0;

    digit_scan_mux #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .eoc(eoc), .du(du),
        .units(units), .tens(tens), .hund(hund), .thou(thou),
        .pol(pol), .ovr(ovr), .udr(udr),
        .ds(ds), .q(q), .upd(upd)
    );

    always #5 clk = ~clk;

    logic [8:0]  exp_q[$];
    logic [15:0] m_sh;
    logic [15:0] m_disp;
    bit          m_pend;
    bit          m_tr;
    int          m_n;
    int          m_idx;

    function automatic logic [3:0] digit(int idx, logic [15:0] d);
        logic [3:0] r;
        bit b2;
        bit b3;
        b2 = 1'b0;
        b3 = 1'b0;
`ifdef DIGIT_BLANK_EN
        b2 = (d[15] == 1'b0) && (d[11:8] == 4'd0);
        b3 = b2 && (d[7:4] == 4'd0);
`endif
        case (idx)
            0:       r = d[15:12];
            1:       r = b2 ? 4'hF : d[11:8];
            2:       r = b3 ? 4'hF : d[7:4];
            default: r = d[3:0];
        endcase
        return r;
    endfunction

    initial begin
        m_n = 0;
        m_pend = 0;
        m_sh = '0;
        m_disp = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0;
                m_pend = 0;
                m_sh = '0;
                m_disp = '0;
                exp_q.delete();
                exp_q.push_back({4'b1000, digit(0, 16'h0), 1'b0});
            end else begin
                m_n++;
                m_tr = ((m_n % FR) == 0) && m_pend;
                if (m_tr) begin
                    m_disp = m_sh;
                    m_pend = 0;
                end
                if (eoc && du) begin
                    m_sh = {thou, pol, ovr, udr, hund, tens, units};
                    m_pend = 1;
                end
                m_idx = (m_n / SD) % 4;
                exp_q.push_back({4'(8 >> m_idx), digit(m_idx, m_disp), m_tr});
            end
        end
    end

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({ds, q, upd} !== e) begin
                    n_fail++;
                    $display("FAIL scan t=%0t ds/q/upd got %b/%b/%b want %b/%b/%b",
                             $time, ds, q, upd, e[8:5], e[4:1], e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idx(int k);
        int b;
        b = 0;
        while (((m_n / SD) % 4) != k && b < 2 * FR) begin
            tick();
            b++;
        end
        if (b >= 2 * FR) begin
            n_fail++;
            $display("FAIL wait_idx timeout got %0d want %0d", (m_n / SD) % 4, k);
        end
    endtask

    task automatic wait_last();
        int b;
        b = 0;
        while ((m_n % FR) != FR - 1 && b < 2 * FR) begin
            tick();
            b++;
        end
        if (b >= 2 * FR) begin
            n_fail++;
            $display("FAIL wait_last timeout got %0d want %0d", m_n % FR, FR - 1);
        end
    endtask

    task automatic conv(logic d, logic th, logic p, logic o, logic u,
                        logic [3:0] h, logic [3:0] t, logic [3:0] un);
        eoc = 1'b1;
        du = d;
        thou = th;
        pol = p;
        ovr = o;
        udr = u;
        hund = h;
        tens = t;
        units = un;
        tick();
        eoc = 1'b0;
        du = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(2 * FR);

        wait_idx(1);
        conv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd8, 4'd7);
        ticks(2 * FR);

        for (int k = 0; k < 3; k++) begin
            ticks(FR / 3);
            conv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 4'd3);
        end
        ticks(FR);

        wait_idx(2);
        conv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd8, 4'd7);
        wait_last();
        conv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5);
        ticks(3 * FR);

        wait_idx(1);
        conv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 4'd4);
        ticks(2 * FR);

        for (int c = 0; c < 20 * FR; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                eoc = 1'b1;
                du = 1'($urandom_range(0, 3) != 0);
                thou = 1'($urandom);
                pol = 1'($urandom);
                ovr = 1'($urandom);
                udr = 1'($urandom);
                hund = 4'($urandom_range(0, 15));
                tens = 4'($urandom_range(0, 15));
                units = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) begin
                    hund = 4'd0;
                    if ($urandom_range(0, 1) == 0) tens = 4'd0;
                end
            end else begin
                eoc = 1'b0;
                du = 1'($urandom);
            end
            tick();
        end
        eoc = 1'b0;
        ticks(FR);

        wait_idx(1);
        conv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 4'd6, 4'd6);
        wait_idx(2);
        ticks(3);
        rst_n = 1'b0;
        ticks(4);
        rst_n = 1'b1;
        ticks(3 * FR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clock cycles each digit strobe is held, legal range 2..256.
REQ-002 SHALL have port clk, input, 1: single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port eoc, input, 1: one-cycle end-of-conversion pulse from the BCD counter chain.
REQ-005 SHALL have port du, input, 1: display-update enable, sampled with eoc.
REQ-006 SHALL have port units, tens, hund, input, 4 each: BCD digits 0..9 from the counter.
REQ-007 SHALL have port thou, input, 1: half-digit (MSD), 0 or 1.
REQ-008 SHALL have ports pol, ovr, udr, input, 1 each: polarity (1 = positive), overrange, underrange.
REQ-009 SHALL have port ds, output, 4: one-hot digit strobe; ds[3]=DS1 (MSD) .. ds[0]=DS4 (LSD).
REQ-010 SHALL have port q, output, 4: data for the strobed digit.
REQ-011 SHALL have port upd, output, 1: one-cycle pulse when the display register loads new data.

Function
REQ-012 SHALL capture {thou,pol,ovr,udr,hund,tens,units} into a shadow register on the rising edge where eoc=1 and du=1, and set a pending flag.
REQ-013 SHALL ignore eoc when du=0; shadow register and pending flag are unchanged.
REQ-014 SHALL run a divider counter 0..SCAN_DIV-1; ds SHALL advance DS1->DS2->DS3->DS4->DS1 on the edge where the divider wraps from SCAN_DIV-1 to 0.
REQ-015 SHALL copy shadow to display register and clear pending only on the edge where ds moves DS4->DS1 while pending=1; upd SHALL be 1 for exactly the following cycle.
REQ-016 SHALL never change displayed data mid-scan, so every DS1..DS4 frame shows one coherent conversion.
REQ-017 On simultaneous capture (REQ-012) and DS4->DS1 transfer in the same cycle, SHALL transfer the old shadow contents, then capture the new value and leave pending=1.
REQ-018 On a second capture before transfer, SHALL overwrite the shadow register; only the newest conversion is displayed.
REQ-019 SHALL register q in the same edge as ds, so q always matches the current strobe: DS1 -> {thou,pol,ovr,udr}; DS2 -> hund; DS3 -> tens; DS4 -> units.
REQ-020 SHALL pass BCD values unchanged; it performs no range checking of digits above 9.

Reset
REQ-021 While rst_n=0, SHALL force ds=4'b1000, q=4'b0000, upd=0, divider=0, pending=0, and shadow and display registers to all zeros.
REQ-022 After rst_n deasserts, SHALL hold DS1 for SCAN_DIV full cycles before advancing.
REQ-023 Reset mid-frame SHALL abandon the frame and discard any pending capture.

Configuration
REQ-024 With macro DIGIT_BLANK_EN defined, SHALL output q=4'b1111 on DS2 when thou=0 and hund=0, and on DS3 when thou=0, hund=0 and tens=0 (leading-zero blanking). DS1 and DS4 are never blanked.
REQ-025 With DIGIT_BLANK_EN undefined, SHALL output raw BCD on every digit, and no blanking logic SHALL be present.

Verification
REQ-026 Reset: rst_n low, then high -> ds=1000, q=0000, upd=0; ds=0100 only after 16 cycles (SCAN_DIV=16).
REQ-027 Update: eoc=du=1 with thou=1, pol=1, ovr=0, udr=0, hund=9, tens=8, units=7 during DS2 -> no change until DS4->DS1; then upd pulses once; DS1 q=1100, DS2 q=1001, DS3 q=1000, DS4 q=0111.
REQ-028 Display hold: eoc=1, du=0 with new digits 1/2/3 -> displayed 9/8/7 unchanged over 3 frames, upd stays 0.
REQ-029 Collision: capture 0/0/5 on the exact DS4->DS1 edge while pending holds 9/8/7 -> this frame shows 9/8/7, next frame shows 0/0/5, upd pulses twice in total.
REQ-030 Blanking: thou=0, hund=0, tens=0, units=5 -> with DIGIT_BLANK_EN, DS2 q=1111, DS3 q=1111, DS4 q=0101; without it, q=0000, 0000, 0101.
REQ-031 Reset mid-frame: rst_n low during DS3 with a capture pending -> after release ds=1000, display register all zeros, and the pending data is never shown.
